// File: rtl/car_seq_pkg.sv
// Shared types and widths for the car frame sequencer and its VGA bus mux.
package car_seq_pkg;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int COL_W  = 9;
    localparam int ADDR_W = 15;
    localparam int DIR_W  = 3;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_REQ,
        S_ERASE_WAIT,
        S_DRAW_REQ,
        S_DRAW_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/vga_bus_mux.sv
// Registered 2:1 selection of the erase/draw engine plot buses; kill forces plot low.
module vga_bus_mux
    import car_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_draw,
    input  logic              kill,
    input  logic [X_W-1:0]    erase_x,
    input  logic [Y_W-1:0]    erase_y,
    input  logic [COL_W-1:0]  erase_colour,
    input  logic              erase_plot,
    input  logic [ADDR_W-1:0] erase_addr,
    input  logic [X_W-1:0]    draw_x,
    input  logic [Y_W-1:0]    draw_y,
    input  logic [COL_W-1:0]  draw_colour,
    input  logic              draw_plot,
    input  logic [ADDR_W-1:0] draw_addr,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [COL_W-1:0]  colour,
    output logic              plot,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            addr   <= '0;
        end else if (sel_draw) begin
            x      <= draw_x;
            y      <= draw_y;
            colour <= draw_colour;
            plot   <= draw_plot & ~kill;
            addr   <= draw_addr;
        end else begin
            x      <= erase_x;
            y      <= erase_y;
            colour <= erase_colour;
            plot   <= erase_plot & ~kill;
            addr   <= erase_addr;
        end
    end

endmodule

// File: rtl/car_frame_sequencer.sv
// Per-frame erase-then-draw scheduler for the car sprite, arbitrating the VGA bus.
// Optional macro SKIP_UNCHANGED_EN skips the engines when the position is unchanged.
module car_frame_sequencer
    import car_seq_pkg::*;
#(
    parameter int FRAME_DIV = 833333,
    parameter int TIMEOUT   = 1023
) (
    input  logic              iClock,
    input  logic              iResetn,
    input  logic              iEnable,
    input  logic [X_W-1:0]    iX,
    input  logic [Y_W-1:0]    iY,
    input  logic [DIR_W-1:0]  iDir,
    output logic              oEraseCar,
    input  logic              iEraseDone,
    input  logic [X_W-1:0]    iEraseX,
    input  logic [Y_W-1:0]    iEraseY,
    input  logic [COL_W-1:0]  iEraseColour,
    input  logic              iErasePlot,
    input  logic [ADDR_W-1:0] iEraseAddr,
    output logic              oDrawCar,
    input  logic              iDrawDone,
    input  logic [X_W-1:0]    iDrawX,
    input  logic [Y_W-1:0]    iDrawY,
    input  logic [COL_W-1:0]  iDrawColour,
    input  logic              iDrawPlot,
    input  logic [ADDR_W-1:0] iDrawAddr,
    output logic [X_W-1:0]    oEngX,
    output logic [Y_W-1:0]    oEngY,
    output logic [DIR_W-1:0]  oEngDir,
    output logic [X_W-1:0]    oX,
    output logic [Y_W-1:0]    oY,
    output logic [COL_W-1:0]  oColour,
    output logic              oPlot,
    output logic [ADDR_W-1:0] oAddress,
    output logic              oFrameDone,
    output logic              oTimeout
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_DIV - 1);
    localparam logic [9:0]       WAIT_LAST = 10'(TIMEOUT - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   frame_cnt_reg;
    logic [9:0]         wait_cnt_reg;
    logic               tick;
    logic               unchanged;
    logic               prev_valid_reg;
    logic               draw_ok_reg;
    logic [X_W-1:0]     prev_x_reg, new_x_reg, eng_x_reg;
    logic [Y_W-1:0]     prev_y_reg, new_y_reg, eng_y_reg;
    logic [DIR_W-1:0]   prev_dir_reg, new_dir_reg, eng_dir_reg;
    logic               erase_car_reg, draw_car_reg, frame_done_reg, timeout_reg;
    logic               sel_draw, kill;

    assign tick = iEnable && (frame_cnt_reg == CNT_LAST);

    always_ff @(posedge iClock) begin
        if (!iResetn)
            frame_cnt_reg <= '0;
        else if (iEnable)
            frame_cnt_reg <= tick ? '0 : frame_cnt_reg + CNT_W'(1);
    end

`ifdef SKIP_UNCHANGED_EN
    assign unchanged = prev_valid_reg && (iX == prev_x_reg) && (iY == prev_y_reg)
                       && (iDir == prev_dir_reg);
`else
    assign unchanged = 1'b0;
`endif

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= '0;
            prev_valid_reg <= 1'b0;
            draw_ok_reg    <= 1'b0;
            prev_x_reg     <= '0;
            prev_y_reg     <= '0;
            prev_dir_reg   <= '0;
            new_x_reg      <= '0;
            new_y_reg      <= '0;
            new_dir_reg    <= '0;
            eng_x_reg      <= '0;
            eng_y_reg      <= '0;
            eng_dir_reg    <= '0;
            erase_car_reg  <= 1'b0;
            draw_car_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            erase_car_reg  <= 1'b0;
            draw_car_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (tick) begin
                        new_x_reg    <= iX;
                        new_y_reg    <= iY;
                        new_dir_reg  <= iDir;
                        wait_cnt_reg <= '0;
                        if (unchanged) begin
                            state_reg      <= S_DONE;
                            frame_done_reg <= 1'b1;
                        end else if (prev_valid_reg) begin
                            state_reg     <= S_ERASE_REQ;
                            erase_car_reg <= 1'b1;
                            eng_x_reg     <= prev_x_reg;
                            eng_y_reg     <= prev_y_reg;
                            eng_dir_reg   <= prev_dir_reg;
                        end else begin
                            state_reg    <= S_DRAW_REQ;
                            draw_car_reg <= 1'b1;
                            eng_x_reg    <= iX;
                            eng_y_reg    <= iY;
                            eng_dir_reg  <= iDir;
                        end
                    end
                end
                S_ERASE_REQ: state_reg <= S_ERASE_WAIT;
                S_ERASE_WAIT: begin
                    if (iEraseDone) begin
                        state_reg    <= S_DRAW_REQ;
                        draw_car_reg <= 1'b1;
                        wait_cnt_reg <= '0;
                        eng_x_reg    <= new_x_reg;
                        eng_y_reg    <= new_y_reg;
                        eng_dir_reg  <= new_dir_reg;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg      <= S_DONE;
                        frame_done_reg <= 1'b1;
                        timeout_reg    <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 10'd1;
                    end
                end
                S_DRAW_REQ: state_reg <= S_DRAW_WAIT;
                S_DRAW_WAIT: begin
                    if (iDrawDone) begin
                        state_reg      <= S_DONE;
                        frame_done_reg <= 1'b1;
                        draw_ok_reg    <= 1'b1;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg      <= S_DONE;
                        frame_done_reg <= 1'b1;
                        timeout_reg    <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 10'd1;
                    end
                end
                S_DONE: begin
                    // Only a completed draw makes the new position the one to erase next frame.
                    if (draw_ok_reg) begin
                        prev_x_reg     <= new_x_reg;
                        prev_y_reg     <= new_y_reg;
                        prev_dir_reg   <= new_dir_reg;
                        prev_valid_reg <= 1'b1;
                    end
                    draw_ok_reg <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign sel_draw = (state_reg == S_DRAW_REQ) || (state_reg == S_DRAW_WAIT);
    assign kill     = !((state_reg == S_ERASE_WAIT) || (state_reg == S_DRAW_WAIT));

    vga_bus_mux u_bus_mux (
        .clk          (iClock),
        .rst_n        (iResetn),
        .sel_draw     (sel_draw),
        .kill         (kill),
        .erase_x      (iEraseX),
        .erase_y      (iEraseY),
        .erase_colour (iEraseColour),
        .erase_plot   (iErasePlot),
        .erase_addr   (iEraseAddr),
        .draw_x       (iDrawX),
        .draw_y       (iDrawY),
        .draw_colour  (iDrawColour),
        .draw_plot    (iDrawPlot),
        .draw_addr    (iDrawAddr),
        .x            (oX),
        .y            (oY),
        .colour       (oColour),
        .plot         (oPlot),
        .addr         (oAddress)
    );

    assign oEraseCar  = erase_car_reg;
    assign oDrawCar   = draw_car_reg;
    assign oFrameDone = frame_done_reg;
    assign oTimeout   = timeout_reg;
    assign oEngX      = eng_x_reg;
    assign oEngY      = eng_y_reg;
    assign oEngDir    = eng_dir_reg;

endmodule

// File: tb/tb_car_frame_sequencer.sv
// Directed bench for car_frame_sequencer (FRAME_DIV=16, TIMEOUT=8).
module tb_car_frame_sequencer;

    logic        clk = 1'b0;
    logic        iResetn, iEnable;
    logic [7:0]  iX;
    logic [6:0]  iY;
    logic [2:0]  iDir;
    logic        oEraseCar, iEraseDone;
    logic [7:0]  iEraseX;
    logic [6:0]  iEraseY;
    logic [8:0]  iEraseColour;
    logic        iErasePlot;
    logic [14:0] iEraseAddr;
    logic        oDrawCar, iDrawDone;
    logic [7:0]  iDrawX;
    logic [6:0]  iDrawY;
    logic [8:0]  iDrawColour;
    logic        iDrawPlot;
    logic [14:0] iDrawAddr;
    logic [7:0]  oEngX;
    logic [6:0]  oEngY;
    logic [2:0]  oEngDir;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [8:0]  oColour;
    logic        oPlot;
    logic [14:0] oAddress;
    logic        oFrameDone, oTimeout;

    int vectors = 0;
    int miscompares = 0;
    int erase_cnt = 0, draw_cnt = 0, fd_cnt = 0, double_cnt = 0;
    logic erase_prev = 1'b0, draw_prev = 1'b0, fd_prev = 1'b0;

    always #5 clk = ~clk;

    car_frame_sequencer #(.FRAME_DIV(16), .TIMEOUT(8)) dut (
        .iClock(clk), .iResetn(iResetn), .iEnable(iEnable),
        .iX(iX), .iY(iY), .iDir(iDir),
        .oEraseCar(oEraseCar), .iEraseDone(iEraseDone),
        .iEraseX(iEraseX), .iEraseY(iEraseY), .iEraseColour(iEraseColour),
        .iErasePlot(iErasePlot), .iEraseAddr(iEraseAddr),
        .oDrawCar(oDrawCar), .iDrawDone(iDrawDone),
        .iDrawX(iDrawX), .iDrawY(iDrawY), .iDrawColour(iDrawColour),
        .iDrawPlot(iDrawPlot), .iDrawAddr(iDrawAddr),
        .oEngX(oEngX), .oEngY(oEngY), .oEngDir(oEngDir),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oAddress(oAddress),
        .oFrameDone(oFrameDone), .oTimeout(oTimeout)
    );

    // Pulse counters; a pulse seen high on two consecutive samples is a width error.
    always @(negedge clk) begin
        if (oEraseCar) erase_cnt++;
        if (oDrawCar) draw_cnt++;
        if (oFrameDone) fd_cnt++;
        if ((oEraseCar && erase_prev) || (oDrawCar && draw_prev) || (oFrameDone && fd_prev))
            double_cnt++;
        erase_prev = oEraseCar;
        draw_prev  = oDrawCar;
        fd_prev    = oFrameDone;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return oEraseCar;
            1:       return oDrawCar;
            default: return oFrameDone;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag);
        int n = 0;
        while (probe(which) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (n < budget) else begin
            miscompares++;
            $error("FAIL %s: observed no pulse in %0d cycles expected a pulse", tag, budget);
        end
    endtask

    task automatic check_eng(input string tag, input int x, input int y, input int d);
        check({tag, "_x"}, oEngX, x);
        check({tag, "_y"}, oEngY, y);
        check({tag, "_dir"}, oEngDir, d);
    endtask

    initial begin
        int snap_e, snap_d, k;
        iResetn = 0; iEnable = 0; iX = 0; iY = 0; iDir = 0;
        iEraseDone = 0; iEraseX = 0; iEraseY = 0; iEraseColour = 0; iErasePlot = 0; iEraseAddr = 0;
        iDrawDone = 0; iDrawX = 0; iDrawY = 0; iDrawColour = 0; iDrawPlot = 0; iDrawAddr = 0;
        repeat (3) @(negedge clk);
        check("rst_erase", oEraseCar, 0);
        check("rst_draw", oDrawCar, 0);
        check("rst_eng", {oEngX, oEngY, oEngDir}, 0);
        check("rst_bus", {oX, oY, oColour, oPlot, oAddress}, 0);
        check("rst_flags", {oFrameDone, oTimeout}, 0);

        // Frame 1: nothing to erase yet, draw only.
        iResetn = 1; iEnable = 1; iX = 10; iY = 20; iDir = 2;
        wait_for(1, 40, "f1_draw_start");
        $display("f1: draw start eng=(%0d,%0d,%0d)", oEngX, oEngY, oEngDir);
        check("f1_no_erase", erase_cnt, 0);
        check_eng("f1_eng", 10, 20, 2);
        iDrawDone = 1;                       // arrives in the REQ cycle: must be ignored
        @(negedge clk); iDrawDone = 0;
        check("f1_req_done_ignored", oFrameDone, 0);
        repeat (2) @(negedge clk);
        check("f1_still_waiting", oFrameDone, 0);
        iDrawDone = 1;
        @(negedge clk); iDrawDone = 0;
        check("f1_frame_done", oFrameDone, 1);
        iX = 11;
        @(negedge clk);
        check("f1_frame_done_once", fd_cnt, 1);

        // Frame 2: erase old position, then draw the new one; bus mux checks.
        wait_for(0, 40, "f2_erase_start");
        $display("f2: erase start eng=(%0d,%0d,%0d)", oEngX, oEngY, oEngDir);
        check_eng("f2_erase_eng", 10, 20, 2);
        @(negedge clk);
        iErasePlot = 1; iEraseX = 40; iEraseY = 50; iEraseColour = 9'h1A5; iEraseAddr = 15'h1234;
        iDrawPlot = 1; iDrawX = 99; iDrawY = 7; iDrawColour = 9'h0F0; iDrawAddr = 15'h0321;
        @(negedge clk);
        check("f2_mux_plot", oPlot, 1);
        check("f2_mux_x", oX, 40);
        check("f2_mux_y", oY, 50);
        check("f2_mux_colour", oColour, 9'h1A5);
        check("f2_mux_addr", oAddress, 15'h1234);
        iErasePlot = 0;
        @(negedge clk);
        check("f2_draw_plot_blocked", oPlot, 0);
        check_eng("f2_eng_held", 10, 20, 2);
        iEraseDone = 1;
        @(negedge clk); iEraseDone = 0;
        check("f2_draw_start", oDrawCar, 1);
        check_eng("f2_draw_eng", 11, 20, 2);
        @(negedge clk);
        check("f2_req_plot_killed", oPlot, 0);
        iDrawDone = 1;
        @(negedge clk); iDrawDone = 0;
        check("f2_draw_plot", oPlot, 1);
        check("f2_draw_x", oX, 99);
        check("f2_frame_done", oFrameDone, 1);
        check("f2_no_timeout", oTimeout, 0);
        iX = 12;
        @(negedge clk);
        check("f2_done_plot_killed", oPlot, 0);
        iDrawPlot = 0;

        // Frame 3: erase engine never answers -> timeout after 8 wait cycles.
        wait_for(0, 40, "f3_erase_start");
        check_eng("f3_erase_eng", 11, 20, 2);
        snap_d = draw_cnt;
        k = 0;
        while (oFrameDone !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        $display("f3: frame done after %0d cycles, timeout=%0b", k, oTimeout);
        check("f3_timeout_latency", k, 9);
        check("f3_timeout_flag", oTimeout, 1);
        check("f3_no_draw", draw_cnt, snap_d);

        // Frame 4: prev regs unchanged by the timeout; reset during DRAW_WAIT.
        wait_for(0, 40, "f4_erase_start");
        check_eng("f4_prev_kept", 11, 20, 2);
        check("f4_timeout_sticky", oTimeout, 1);
        @(negedge clk); iEraseDone = 1;
        @(negedge clk); iEraseDone = 0;
        check("f4_draw_start", oDrawCar, 1);
        check_eng("f4_draw_eng", 12, 20, 2);
        @(negedge clk);
        iResetn = 0; iDrawPlot = 1; iDrawX = 77;
        @(negedge clk);
        $display("f4: reset mid-draw, timeout=%0b plot=%0b", oTimeout, oPlot);
        check("f4_rst_pulses", {oEraseCar, oDrawCar, oFrameDone, oTimeout}, 0);
        check("f4_rst_eng", {oEngX, oEngY, oEngDir}, 0);
        check("f4_rst_bus", {oX, oY, oColour, oPlot, oAddress}, 0);
        iResetn = 1; iDrawPlot = 0;
        snap_e = erase_cnt;

        // Frame 5: after reset, draw only.
        wait_for(1, 40, "f5_draw_start");
        check("f5_no_erase", erase_cnt, snap_e);
        check_eng("f5_draw_eng", 12, 20, 2);
        @(negedge clk); iDrawDone = 1;
        @(negedge clk); iDrawDone = 0;
        check("f5_frame_done", oFrameDone, 1);
        @(negedge clk);

        // Frame 6: unchanged position.
        snap_e = erase_cnt; snap_d = draw_cnt;
`ifdef SKIP_UNCHANGED_EN
        wait_for(2, 40, "f6_skip_done");
        $display("f6: unchanged frame skipped");
        check("f6_no_erase", erase_cnt, snap_e);
        check("f6_no_draw", draw_cnt, snap_d);
`else
        wait_for(0, 40, "f6_erase_start");
        $display("f6: unchanged frame still erases");
        check_eng("f6_erase_eng", 12, 20, 2);
        @(negedge clk); iEraseDone = 1;
        @(negedge clk); iEraseDone = 0;
        check("f6_draw_start", oDrawCar, 1);
        @(negedge clk); iDrawDone = 1;
        @(negedge clk); iDrawDone = 0;
        check("f6_frame_done", oFrameDone, 1);
`endif

        // Disabled: no more ticks.
        iEnable = 0;
        snap_e = erase_cnt; snap_d = draw_cnt;
        repeat (40) @(negedge clk);
        check("dis_no_start", erase_cnt + draw_cnt, snap_e + snap_d);
        check("pulse_width", double_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/car_frame_sequencer.md
Name: car_frame_sequencer

Overview:
- Per-frame scheduler for the car sprite.
- On each frame tick it runs the car-erase engine at the previous position, then the car-draw engine at the new position.
- Arbitrates the shared VGA plot bus (x, y, colour, plot) and the background-memory address between the two engines.
- Sits between game logic (position/direction source) and the erase/draw engines plus the VGA adapter.

Parameters:
- FRAME_DIV, 833333: clock cycles per frame tick (50 MHz / 60).
- TIMEOUT, 1023: maximum cycles to wait for an engine done before aborting.

Ports:
- iClock  in  1  system clock.
- iResetn  in  1  synchronous active-low reset.
- iEnable  in  1  sequencer runs when high; frame counter holds when low.
- iX  in  8  new car upper-left x.
- iY  in  7  new car upper-left y.
- iDir  in  3  new car direction (0..7).
- oEraseCar  out  1  one-cycle start pulse to erase engine.
- iEraseDone  in  1  erase engine done pulse.
- iEraseX/iEraseY/iEraseColour/iErasePlot/iEraseAddr  in  8/7/9/1/15  erase engine bus.
- oDrawCar  out  1  one-cycle start pulse to draw engine.
- iDrawDone  in  1  draw engine done pulse.
- iDrawX/iDrawY/iDrawColour/iDrawPlot/iDrawAddr  in  8/7/9/1/15  draw engine bus.
- oEngX  out  8  position handed to the active engine.
- oEngY  out  7  position handed to the active engine.
- oEngDir  out  3  direction handed to the active engine.
- oX/oY/oColour/oPlot  out  8/7/9/1  muxed VGA bus.
- oAddress  out  15  muxed memory address.
- oFrameDone  out  1  one-cycle pulse when the frame update completes.
- oTimeout  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (iResetn=0 at posedge iClock): state IDLE; frame counter 0; prevValid 0; prev/new position registers 0; all outputs 0.
- Frame counter: counts 0..FRAME_DIV-1 while iEnable=1. tick=1 for one cycle at FRAME_DIV-1, then wraps to 0.
- States: IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, DONE.
- IDLE: on tick, latch iX/iY/iDir into new regs.
  - prevValid=1: go to ERASE_REQ.
  - prevValid=0: go to DRAW_REQ (first frame, nothing to erase).
  - A tick arriving outside IDLE is dropped, not queued.
- ERASE_REQ: oEraseCar=1 for exactly one cycle; oEng* = prev regs; go to ERASE_WAIT.
- ERASE_WAIT: oEng* = prev regs, held stable; bus mux selects the erase engine.
  - iEraseDone=1: go to DRAW_REQ.
  - Wait counter reaches TIMEOUT: set oTimeout, go to DONE.
- DRAW_REQ / DRAW_WAIT: same rules as the erase states, using oDrawCar, iDrawDone, new regs and the draw engine bus.
- DONE: oFrameDone=1 for one cycle; on a successful draw, copy new regs to prev regs and set prevValid=1; go to IDLE.
  - After a timeout, prev regs are unchanged.
- Wait counter: 10 bits; cleared on entry to each REQ state.
- Bus mux is registered, giving 1 cycle latency from engine bus to oX/oY/oColour/oPlot/oAddress.
  - Only one engine is selected at a time.
  - oPlot is forced 0 in IDLE, REQ and DONE states, and one cycle afterwards, so a stray engine plot never reaches the VGA.
- Done pulse in the same cycle as its REQ state is ignored; only the WAIT states sample done.
- Reset mid-operation: returns to IDLE and clears prevValid. The next frame draws without erasing.
- iEnable=0 mid-operation: the current sequence completes; no new tick is generated.

Optional Feature:
- Macro: SKIP_UNCHANGED_EN.
- Defined: in IDLE on tick, if prevValid=1 and the latched iX/iY/iDir equal the prev regs, skip erase and draw. Go straight to DONE; oFrameDone still pulses; no engine start pulses.
- Undefined: every tick runs the full erase+draw sequence (draw only on the first frame).

Decomposition:
- Package car_seq_pkg holds:
  - state enum;
  - widths X_W=8, Y_W=7, COL_W=9, ADDR_W=15, DIR_W=3;
  - screen limits 160x120.
- Sub-module vga_bus_mux: registered 2:1 selection of {x, y, colour, plot, addr} with a plot-kill input.
- Frame divider and FSM live in the top module.

Test Plan:
- FRAME_DIV=16, first tick with iX=10, iY=20, iDir=2 -> no oEraseCar; oDrawCar pulses with oEng*=(10,20,2); after iDrawDone, oFrameDone pulses once; prevValid=1.
- Second tick with (11,20,2) -> oEraseCar pulses with oEng*=(10,20,2); after iEraseDone, oDrawCar with (11,20,2); oFrameDone follows.
- Engine bus mux -> during ERASE_WAIT, iErasePlot=1 with iEraseX=40 gives oPlot=1, oX=40 one cycle later; an iDrawPlot=1 pulse in the same window gives oPlot unaffected.
- Timeout with TIMEOUT=8 and iEraseDone held 0 -> oTimeout=1 after 8 wait cycles; oFrameDone pulses; prev regs unchanged; no oDrawCar.
- Reset asserted during DRAW_WAIT -> next cycle all outputs 0, state IDLE; next tick draws only, with no erase.
- SKIP_UNCHANGED_EN defined, same (11,20,2) on two ticks -> second tick gives no start pulses and oFrameDone=1 within 2 cycles.
